// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential unsigned multiplier.
// Holds the FSM state encoding, cycle-count helpers and a width-generic mod-3 reducer.
// Pure declarations: no latency or backpressure of its own.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest value the mod-3 reducer accepts; narrower inputs are zero-extended.
    localparam int MOD3_MAXW = 128;

    // Number of shift-add steps for one product.
    function automatic int ncyc(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Counter width able to hold the step count itself.
    function automatic int cnt_w(input int width, input int bpc);
        return $clog2((width / bpc) + 1);
    endfunction

    // 4^k == 1 (mod 3), so summing 2-bit digits preserves the residue.
    // The running sum is folded back into 0..2 after each digit.
    function automatic logic [1:0] mod3(input logic [MOD3_MAXW-1:0] x);
        logic [2:0] s;
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < MOD3_MAXW / 2; i++) begin
            s = {1'b0, r} + {1'b0, x[2*i +: 2]};
            r = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_residue3.sv
// Combinational mod-3 reducer for a W-bit unsigned value.
// Latency: zero cycles, pure combinational.
// Backpressure: none, no handshake.
module mult_residue3
    import mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [1:0]   r
);

    if (W > MOD3_MAXW) begin : g_width_check
        $error("mult_residue3: W exceeds MOD3_MAXW");
    end

    assign r = mod3(MOD3_MAXW'(x));

endmodule

// File: rtl/mult_seq_unsigned_rc.sv
// Sequential unsigned radix-2^BPC shift-add multiplier with optional mod-3 residue check (MULT_RESIDUE_CHECK_EN).
// Latency: accept at edge T -> out_valid from edge T+WIDTH/BPC+1, independent of operand values.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid && out_ready.
module mult_seq_unsigned_rc
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               err,
    output logic               busy
);

    localparam int NCYC  = ncyc(WIDTH, BPC);
    localparam int CNT_W = cnt_w(WIDTH, BPC);

    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
        $error("mult_seq_unsigned_rc: need WIDTH >= 2 and BPC dividing WIDTH");
    end

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] p_q;
    logic               accept;
    logic               step;
    logic               load;
    logic               fire;

    assign accept = in_valid && (state == IDLE);
    assign step   = (state == CALC) && (cnt != '0);
    assign load   = (state == CALC) && (cnt == '0);
    assign fire   = out_valid && out_ready;

    // Partial product for the BPC multiplier bits currently at the bottom of b_sh;
    // a_sh already carries the positional shift.
    assign pp = {{(2*WIDTH-BPC){1'b0}}, b_sh[BPC-1:0]} * a_sh;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; the extra CALC cycle at cnt==0 registers the result.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift-add datapath: operands captured at accept, one radix-2^BPC digit per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
        end else if (accept) begin
            acc  <= '0;
            a_sh <= {{WIDTH{1'b0}}, a};
            b_sh <= b;
            cnt  <= CNT_W'(NCYC);
        end else if (step) begin
            acc  <= acc + pp;
            a_sh <= a_sh << BPC;
            b_sh <= b_sh >> BPC;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    // Result register: loaded on entry to DONE, zeroed on the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else if (load) begin
            p_q <= acc;
        end else if (fire) begin
            p_q <= '0;
        end
    end

    assign p = p_q;

`ifdef MULT_RESIDUE_CHECK_EN
    logic [1:0] ra_c;
    logic [1:0] rb_c;
    logic [1:0] rp_c;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] rprod;
    logic [1:0] rexp;
    logic       err_q;

    mult_residue3 #(.W(WIDTH))   u_res_a (.x(a),   .r(ra_c));
    mult_residue3 #(.W(WIDTH))   u_res_b (.x(b),   .r(rb_c));
    mult_residue3 #(.W(2*WIDTH)) u_res_p (.x(acc), .r(rp_c));

    // Operand residues are taken from the ports at accept, independent of the shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= '0;
            rb <= '0;
        end else if (accept) begin
            ra <= ra_c;
            rb <= rb_c;
        end
    end

    assign rprod = {2'b00, ra} * {2'b00, rb};
    assign rexp  = mod3(MOD3_MAXW'(rprod));

    // Mismatch flag registered alongside p and cleared with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (load) begin
            err_q <= (rp_c != rexp);
        end else if (fire) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
